sync_fifo_fwft_ctl: RTL

//  Single-clock first-word-fall-through (FWFT) FIFO for intra-domain buffering in the switch datapath.

---
 rtl/sync_fifo_fwft_ctl_pkg.sv | 16 +
 rtl/sdp_ram_reg.sv | 45 ++++
 rtl/sync_fifo_fwft_ctl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_fwft_ctl_pkg.sv
// sync_fifo_fwft_ctl_pkg: elaboration-time helpers shared by the FWFT FIFO controller.
package sync_fifo_fwft_ctl_pkg;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sdp_ram_reg.sv
// sdp_ram_reg: simple-dual-port RAM with registered read data; storage is not reset.
module sdp_ram_reg #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_W     = 9,
    parameter int RAM_STYLE  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_W-1:0]     i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);
    localparam int DEPTH = 2 ** ADDR_W;

    generate
        if (RAM_STYLE == 1) begin : g_bram
            (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

            // Write port and registered read port, block RAM mapping
            always_ff @(posedge i_clk) begin
                if (i_wr_en) begin
                    mem[i_wr_addr] <= i_wr_data;
                end
                if (i_rd_en) begin
                    o_rd_data <= mem[i_rd_addr];
                end
            end
        end else begin : g_lutram
            (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

            // Write port and registered read port, LUT RAM mapping
            always_ff @(posedge i_clk) begin
                if (i_wr_en) begin
                    mem[i_wr_addr] <= i_wr_data;
                end
                if (i_rd_en) begin
                    o_rd_data <= mem[i_rd_addr];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_fwft_ctl.sv
// sync_fifo_fwft_ctl: single-clock FWFT FIFO with exact count, thresholds, sticky errors and flush.
// Define SYNC_FIFO_FWFT_PEAK_EN to add the peak-occupancy tracker (i_peak_clr / o_peak_cnt).
module sync_fifo_fwft_ctl
    import sync_fifo_fwft_ctl_pkg::*;
#(
    parameter int  DATA_WIDTH   = 64,
    parameter int  FIFO_DEPTH   = 512,
    parameter int  RAM_STYLE    = 1,
    localparam int C_REAL_DEPTH = 2 ** clog2(FIFO_DEPTH),
    localparam int CNT_W        = clog2(C_REAL_DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_full,
    output logic                  o_afull,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_empty,
    output logic                  o_aempty,
    output logic [CNT_W-1:0]      o_cnt,
    input  logic [CNT_W-1:0]      i_afull_th,
    input  logic [CNT_W-1:0]      i_aempty_th,
    input  logic                  i_flush,
    input  logic                  i_clr_err,
`ifdef SYNC_FIFO_FWFT_PEAK_EN
    input  logic                  i_peak_clr,
    output logic [CNT_W-1:0]      o_peak_cnt,
`endif
    output logic                  o_overflow,
    output logic                  o_underflow
);
    // C_REAL_DEPTH is a power of two, so the RAM pointers are exactly one bit narrower than the count.
    logic [CNT_W-2:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, ram_cnt_q, ram_cnt_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  dout_vld_q, dout_vld_d, cache_vld_q, cache_vld_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d, cache_q, cache_d;
    logic                  overflow_q, overflow_d, underflow_q, underflow_d;
    logic                  wr_acc_s, rd_acc_s, ram_re_s;
    logic [1:0]            stage_occ_s;
    logic [DATA_WIDTH-1:0] ram_rdata_s;

    assign o_cnt       = cnt_q;
    assign o_full      = (cnt_q == CNT_W'(C_REAL_DEPTH));
    assign o_afull     = (cnt_q >= i_afull_th);
    assign o_aempty    = (cnt_q <= i_aempty_th);
    assign o_empty     = ~dout_vld_q;
    assign o_rd_data   = dout_q;
    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;

    // Acceptance and prefetch: keep up to two words staged or in flight, plus one more on a pop
    always_comb begin
        wr_acc_s    = i_wr_en & ~o_full & ~i_flush;
        rd_acc_s    = i_rd_en & ~o_empty & ~i_flush;
        stage_occ_s = {1'b0, rd_pend_q} + {1'b0, dout_vld_q} + {1'b0, cache_vld_q};
        ram_re_s    = (ram_cnt_q != {CNT_W{1'b0}}) & ~i_flush &
                      ((stage_occ_s < 2'd2) | rd_acc_s);
    end

    // Next-state for pointers, counts, output stage and sticky flags
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        ram_cnt_d   = ram_cnt_q;
        rd_pend_d   = ram_re_s;
        dout_vld_d  = dout_vld_q;
        dout_d      = dout_q;
        cache_vld_d = cache_vld_q;
        cache_d     = cache_q;
        overflow_d  = (i_wr_en & o_full & ~i_flush) | (overflow_q & ~i_clr_err);
        underflow_d = (i_rd_en & o_empty & ~i_flush) | (underflow_q & ~i_clr_err);

        if (i_flush) begin
            wr_ptr_d    = {(CNT_W-1){1'b0}};
            rd_ptr_d    = {(CNT_W-1){1'b0}};
            cnt_d       = {CNT_W{1'b0}};
            ram_cnt_d   = {CNT_W{1'b0}};
            rd_pend_d   = 1'b0;
            dout_vld_d  = 1'b0;
            cache_vld_d = 1'b0;
        end else begin
            wr_ptr_d  = wr_acc_s ? wr_ptr_q + (CNT_W-1)'(1'b1) : wr_ptr_q;
            rd_ptr_d  = ram_re_s ? rd_ptr_q + (CNT_W-1)'(1'b1) : rd_ptr_q;
            cnt_d     = cnt_q + CNT_W'(wr_acc_s) - CNT_W'(rd_acc_s);
            ram_cnt_d = ram_cnt_q + CNT_W'(wr_acc_s) - CNT_W'(ram_re_s);

            // The cache always holds the older word, so it refills the head before a returning read.
            if (rd_acc_s) begin
                if (cache_vld_q) begin
                    dout_d      = cache_q;
                    cache_vld_d = rd_pend_q;
                    cache_d     = rd_pend_q ? ram_rdata_s : cache_q;
                end else begin
                    dout_d     = rd_pend_q ? ram_rdata_s : dout_q;
                    dout_vld_d = rd_pend_q;
                end
            end else if (rd_pend_q) begin
                if (dout_vld_q) begin
                    cache_d     = ram_rdata_s;
                    cache_vld_d = 1'b1;
                end else begin
                    dout_d     = ram_rdata_s;
                    dout_vld_d = 1'b1;
                end
            end else begin
                dout_d  = dout_q;
                cache_d = cache_q;
            end
        end
    end

    // State registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q    <= {(CNT_W-1){1'b0}};
            rd_ptr_q    <= {(CNT_W-1){1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            ram_cnt_q   <= {CNT_W{1'b0}};
            rd_pend_q   <= 1'b0;
            dout_vld_q  <= 1'b0;
            dout_q      <= {DATA_WIDTH{1'b0}};
            cache_vld_q <= 1'b0;
            cache_q     <= {DATA_WIDTH{1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            ram_cnt_q   <= ram_cnt_d;
            rd_pend_q   <= rd_pend_d;
            dout_vld_q  <= dout_vld_d;
            dout_q      <= dout_d;
            cache_vld_q <= cache_vld_d;
            cache_q     <= cache_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sdp_ram_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (CNT_W - 1),
        .RAM_STYLE  (RAM_STYLE)
    ) u_ram (
        .i_clk      (i_clk),
        .i_wr_en    (wr_acc_s),
        .i_wr_addr  (wr_ptr_q),
        .i_wr_data  (i_wr_data),
        .i_rd_en    (ram_re_s),
        .i_rd_addr  (rd_ptr_q),
        .o_rd_data  (ram_rdata_s)
    );

`ifdef SYNC_FIFO_FWFT_PEAK_EN
    logic [CNT_W-1:0] peak_q, peak_d;

    // Peak tracker: restarts on flush, reloads the live count on clear
    always_comb begin
        if (i_flush) begin
            peak_d = {CNT_W{1'b0}};
        end else if (i_peak_clr) begin
            peak_d = cnt_q;
        end else if (cnt_q > peak_q) begin
            peak_d = cnt_q;
        end else begin
            peak_d = peak_q;
        end
    end

    // Peak register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            peak_q <= {CNT_W{1'b0}};
        end else begin
            peak_q <= peak_d;
        end
    end

    assign o_peak_cnt = peak_q;
`endif

endmodule
